inout_sram_arbiter: RTL and testbench
=====================================

INOUT_SRAM_ARBITER -- requirements
Module: inout_sram_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of burst requesters (port 0 = DMA loader, port 1 = PE engine).
REQ-002 Parameter DEPTH_WORDS, default 196608, valid 16-bit word locations (six 32768-word banks).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  NUM_REQ  burst request per requester, held until req_ready.
REQ-006 req_we  input  NUM_REQ  1 = write burst, 0 = read burst.
REQ-007 req_base  input  NUM_REQ x 18  start word address.
REQ-008 req_len  input  NUM_REQ x 16  beat count minus one (0 = 1 beat).
REQ-009 req_ready  output  NUM_REQ  one-cycle pulse: burst accepted.
REQ-010 wvalid / wdata  input  NUM_REQ / NUM_REQ x 16  write beat data from requester.
REQ-011 wready  output  NUM_REQ  write beat consumed this cycle.
REQ-012 rvalid / rdata  output  NUM_REQ / 32  read beat returned; rdata is sign-extended 16-bit word, shared bus.
REQ-013 done / err  output  NUM_REQ / NUM_REQ  one-cycle pulse: burst finished / burst aborted on range error.
REQ-014 mem_cs, mem_oe, mem_web  output  1 each  SRAM chip select, output enable, active-low write enable.
REQ-015 mem_addr / mem_wdata / mem_rdata  output 18 / output 16 / input 32  SRAM address, write data, read data (valid cycle after read address).

Function
REQ-016 States IDLE, BURST, DRAIN; IDLE -> BURST on any req_valid; BURST -> DRAIN after last read beat; BURST -> IDLE after last write beat; DRAIN -> IDLE after one cycle.
REQ-017 Arbitration round-robin among req_valid, evaluated only in IDLE; priority pointer moves to one past granted requester; after reset requester 0 highest.
REQ-018 On grant: req_ready pulses for granted requester, base and len latched, owner index latched; the grant cycle issues no SRAM access.
REQ-019 Read burst: one beat per BURST cycle, mem_cs=1, mem_oe=1, mem_web=1, mem_addr=current address; rvalid to owner exactly one cycle later with rdata=mem_rdata.
REQ-020 Write burst: beat issues only in cycles where owner wvalid=1; then mem_cs=1, mem_web=0, mem_oe=0, mem_wdata=wdata, wready=1; wvalid=0 stalls with mem_cs=0.
REQ-021 Address increments by 1 per issued beat; beat count compares to latched len; no wrap.
REQ-022 done pulses for owner: write -- cycle of last beat; read -- cycle of last rvalid (DRAIN).
REQ-023 If base+len >= DEPTH_WORDS at grant: no SRAM access, err pulses one cycle after grant, state -> IDLE, pointer still advances.
REQ-024 Idle defaults: mem_cs=0, mem_oe=0, mem_web=1, mem_addr/mem_wdata hold last value; all pulses 0.
REQ-025 req_valid of non-owners ignored during BURST/DRAIN; owner deasserting wvalid indefinitely is legal (no timeout).
REQ-026 Back-to-back: new grant possible in the first IDLE cycle after DRAIN/write completion; throughput = len+1 beats per len+3 cycles (read).

Reset
REQ-027 rst asserted: state IDLE, pointer 0, counters 0, mem_cs=0, mem_oe=0, mem_web=1, mem_addr=0, mem_wdata=0, all pulses/valids 0, immediately (asynchronous).
REQ-028 rst mid-burst abandons the burst; no done/err issued; partial writes remain in SRAM.

Structure
REQ-029 Package inout_arb_pkg holds state enum, DEPTH_WORDS default, address/length widths.
REQ-030 One sub-module rr_arbiter (NUM_REQ-wide request vector, one-hot grant, pointer update on enable).

Verification
REQ-031 Single read, port 1, base=0x00010, len=3 -> mem_addr 0x10..0x13 consecutive cycles, 4 rvalid one cycle later, done with 4th rvalid.
REQ-032 Write port 0, base=0x2FFFE, len=1, wvalid toggled 1,0,1 -> two writes at 0x2FFFE, 0x2FFFF, stall cycle mem_cs=0, done on second beat.
REQ-033 Both req_valid held continuously, len=0 each -> grants alternate 0,1,0,1; no starvation over 20 bursts.
REQ-034 Read base=0x2FFFF, len=1 (end 0x30000) -> no mem_cs, err pulse, next request granted normally.
REQ-035 rst pulsed during read burst beat 2 of 8 -> outputs at reset values within same cycle, no done, subsequent burst correct.
REQ-036 Write 0xA5A5..., read back with bit15=1 -> rdata upper 16 bits all ones.

Source files
------------

// File: rtl/inout_arb_pkg.sv
// Shared widths, state encoding and helpers for the SRAM burst arbiter.
package inout_arb_pkg;
  localparam int ADDR_W              = 18;
  localparam int LEN_W               = 16;
  localparam int WORD_W              = 16;
  localparam int RDATA_W             = 32;
  localparam int DEPTH_WORDS_DEFAULT = 196608;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } arb_state_e;

  function automatic logic [RDATA_W-1:0] signExtendWord(input logic [WORD_W-1:0] word);
    return {{(RDATA_W-WORD_W){word[WORD_W-1]}}, word};
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting from a rotating priority pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grantIdx_o,
  output logic               anyGrant_o
);
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] sel;
  int               sum;

  // Scan requesters starting at the pointer; the first one found wins.
  always_comb begin
    grant_o    = '0;
    grantIdx_o = '0;
    anyGrant_o = 1'b0;
    sum        = 0;
    sel        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(ptr_q) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      sel = IDX_W'(sum);
      if (!anyGrant_o && req_i[sel]) begin
        anyGrant_o   = 1'b1;
        grant_o[sel] = 1'b1;
        grantIdx_o   = sel;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en_i && anyGrant_o)
      ptr_d = (int'(grantIdx_o) == NUM_REQ - 1) ? '0 : grantIdx_o + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/inout_sram_arbiter.sv
// Burst arbiter granting SRAM access to NUM_REQ requesters for read/write bursts.
module inout_sram_arbiter
  import inout_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_base,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             wvalid,
  input  logic [NUM_REQ-1:0][WORD_W-1:0] wdata,
  output logic [NUM_REQ-1:0]             wready,
  output logic [NUM_REQ-1:0]             rvalid,
  output logic [RDATA_W-1:0]             rdata,
  output logic [NUM_REQ-1:0]             done,
  output logic [NUM_REQ-1:0]             err,
  output logic                           mem_cs,
  output logic                           mem_oe,
  output logic                           mem_web,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [WORD_W-1:0]              mem_wdata,
  input  logic [RDATA_W-1:0]             mem_rdata
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = ADDR_W + 2;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               rvalid_q, rvalid_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  addrHold_q, addrHold_d;
  logic [WORD_W-1:0]  wdataHold_q, wdataHold_d;

  logic               arbEn;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grantIdx;
  logic               anyGrant;
  logic               rangeErr;
  logic               beat;
  logic [NUM_REQ-1:0] ownerOh;
  logic               unusedRdataHi;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) uArb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_valid),
    .en_i      (arbEn),
    .grant_o   (grant),
    .grantIdx_o(grantIdx),
    .anyGrant_o(anyGrant)
  );

  assign rangeErr      = (SUM_W'(req_base[grantIdx]) + SUM_W'(req_len[grantIdx])) >= SUM_W'(DEPTH_WORDS);
  assign ownerOh       = NUM_REQ'(1) << owner_q;
  assign rvalid        = rvalid_q ? ownerOh : '0;
  assign err           = err_q ? ownerOh : '0;
  assign rdata         = signExtendWord(mem_rdata[WORD_W-1:0]);
  assign unusedRdataHi = ^mem_rdata[RDATA_W-1:WORD_W];

  // Outside a burst the SRAM bus parks on the last issued address and data.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    addrHold_d  = addrHold_q;
    wdataHold_d = wdataHold_q;
    arbEn       = 1'b0;
    beat        = 1'b0;
    req_ready   = '0;
    wready      = '0;
    done        = '0;
    mem_cs      = 1'b0;
    mem_oe      = 1'b0;
    mem_web     = 1'b1;
    mem_addr    = addrHold_q;
    mem_wdata   = wdataHold_q;
    case (state_q)
      IDLE: begin
        arbEn = 1'b1;
        if (anyGrant) begin
          req_ready = grant;
          owner_d   = grantIdx;
          we_d      = req_we[grantIdx];
          addr_d    = req_base[grantIdx];
          len_d     = req_len[grantIdx];
          cnt_d     = '0;
          if (rangeErr) err_d   = 1'b1;
          else          state_d = BURST;
        end
      end
      BURST: begin
        mem_addr = addr_q;
        if (we_q) begin
          if (wvalid[owner_q]) begin
            beat            = 1'b1;
            mem_cs          = 1'b1;
            mem_web         = 1'b0;
            mem_wdata       = wdata[owner_q];
            wdataHold_d     = wdata[owner_q];
            wready[owner_q] = 1'b1;
            if (cnt_q == len_q) begin
              done[owner_q] = 1'b1;
              state_d       = IDLE;
            end
          end
        end else begin
          beat     = 1'b1;
          mem_cs   = 1'b1;
          mem_oe   = 1'b1;
          rvalid_d = 1'b1;
          if (cnt_q == len_q) state_d = DRAIN;
        end
        if (beat) begin
          addr_d     = addr_q + 1'b1;
          cnt_d      = cnt_q + 1'b1;
          addrHold_d = addr_q;
        end
      end
      DRAIN: begin
        done[owner_q] = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      addrHold_q  <= '0;
      wdataHold_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      addrHold_q  <= addrHold_d;
      wdataHold_q <= wdataHold_d;
    end
  end
endmodule

// File: tb/tb_inout_sram_arbiter.sv
// Directed bench for inout_sram_arbiter with a simple behavioural SRAM.
module tb_inout_sram_arbiter;
  logic             clk;
  logic             rst;
  logic [1:0]       req_valid, req_we;
  logic [1:0][17:0] req_base;
  logic [1:0][15:0] req_len;
  logic [1:0]       req_ready;
  logic [1:0]       wvalid;
  logic [1:0][15:0] wdata;
  logic [1:0]       wready, rvalid, done, err;
  logic [31:0]      rdata;
  logic             mem_cs, mem_oe, mem_web;
  logic [17:0]      mem_addr;
  logic [15:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  logic [15:0]      sram [0:262143];
  int               numCompared;
  int               numMismatched;

  inout_sram_arbiter #(.NUM_REQ(2), .DEPTH_WORDS(196608)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_base(req_base), .req_len(req_len),
    .req_ready(req_ready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .rvalid(rvalid), .rdata(rdata), .done(done), .err(err),
    .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_web(mem_web),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM returns read data one cycle after the address, with junk in the upper half.
  always @(posedge clk) begin
    if (mem_cs && !mem_web) sram[mem_addr] <= mem_wdata;
    if (mem_cs && mem_oe)   mem_rdata <= {16'hBEEF, sram[mem_addr]};
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int port, input logic we, input logic [17:0] base,
                               input logic [15:0] len);
    req_valid[port] = 1'b1;
    req_we[port]    = we;
    req_base[port]  = base;
    req_len[port]   = len;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] expRd [4];
    int          grants0, grants1;
    logic        got;
    expRd = '{32'h0000_0011, 32'hFFFF_8022, 32'h0000_0033, 32'h0000_7FFF};
    numCompared = 0;
    numMismatched = 0;
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_base = '0; req_len = '0;
    wvalid = '0; wdata = '0;
    sram[18'h10] = 16'h0011;
    sram[18'h11] = 16'h8022;
    sram[18'h12] = 16'h0033;
    sram[18'h13] = 16'h7FFF;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rstCtl", {29'b0, mem_cs, mem_oe, mem_web}, 32'h1);
    checkOutput("rstAddr", {14'b0, mem_addr}, 32'h0);
    checkOutput("rstWdata", {16'b0, mem_wdata}, 32'h0);
    checkOutput("rstPulses", {24'b0, req_ready, rvalid, done, err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single read burst, port 1, base 0x10, len 3
    @(negedge clk);
    applyStimulus(1, 1'b0, 18'h00010, 16'd3);
    #1;
    checkOutput("rdGrant", {30'b0, req_ready}, 32'h2);
    checkOutput("rdGrantCs", {31'b0, mem_cs}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (i < 4) begin
        checkOutput("rdAddr", {14'b0, mem_addr}, 32'h10 + i);
        checkOutput("rdCtl", {29'b0, mem_cs, mem_oe, mem_web}, 32'h7);
      end else begin
        checkOutput("rdDrainCs", {31'b0, mem_cs}, 32'h0);
      end
      if (i >= 1) begin
        checkOutput("rdValid", {30'b0, rvalid}, 32'h2);
        checkOutput("rdData", rdata, expRd[i-1]);
      end else begin
        checkOutput("rdValidFirst", {30'b0, rvalid}, 32'h0);
      end
      checkOutput("rdDone", {30'b0, done}, (i == 4) ? 32'h2 : 32'h0);
    end
    @(negedge clk);
    #1;
    checkOutput("rdIdle", {26'b0, done, rvalid, mem_cs, mem_oe}, 32'h0);
    checkOutput("rdHoldAddr", {14'b0, mem_addr}, 32'h13);

    // Write burst, port 0, base 0x2FFFE, len 1, wvalid 1,0,1
    @(negedge clk);
    applyStimulus(0, 1'b1, 18'h2FFFE, 16'd1);
    #1;
    checkOutput("wrGrant", {30'b0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = '0; wvalid = 2'b01; wdata[0] = 16'hA5A5;
    #1;
    checkOutput("wrBeat0Ctl", {29'b0, mem_cs, mem_oe, mem_web}, 32'h4);
    checkOutput("wrBeat0Addr", {14'b0, mem_addr}, 32'h2FFFE);
    checkOutput("wrBeat0Data", {16'b0, mem_wdata}, 32'hA5A5);
    checkOutput("wrBeat0Rdy", {28'b0, wready, done}, 32'h4);
    @(negedge clk);
    wvalid = 2'b00;
    #1;
    checkOutput("wrStallCs", {31'b0, mem_cs}, 32'h0);
    checkOutput("wrStallRdy", {28'b0, wready, done}, 32'h0);
    @(negedge clk);
    wvalid = 2'b01; wdata[0] = 16'h5A5A;
    #1;
    checkOutput("wrBeat1Ctl", {29'b0, mem_cs, mem_oe, mem_web}, 32'h4);
    checkOutput("wrBeat1Addr", {14'b0, mem_addr}, 32'h2FFFF);
    checkOutput("wrBeat1Data", {16'b0, mem_wdata}, 32'h5A5A);
    checkOutput("wrDone", {28'b0, wready, done}, 32'h5);
    @(negedge clk);
    wvalid = 2'b00;
    #1;
    checkOutput("wrIdle", {29'b0, mem_cs, done}, 32'h0);
    checkOutput("wrMem0", {16'b0, sram[18'h2FFFE]}, 32'hA5A5);
    checkOutput("wrMem1", {16'b0, sram[18'h2FFFF]}, 32'h5A5A);

    // Read back 0xA5A5: sign extension
    @(negedge clk);
    applyStimulus(0, 1'b0, 18'h2FFFE, 16'd0);
    #1;
    checkOutput("sxGrant", {30'b0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = '0;
    #1;
    checkOutput("sxAddr", {14'b0, mem_addr}, 32'h2FFFE);
    @(negedge clk);
    #1;
    checkOutput("sxData", rdata, 32'hFFFF_A5A5);
    checkOutput("sxDone", {28'b0, rvalid, done}, 32'h5);

    // Range error, port 1, base 0x2FFFF len 1, then a normal request
    @(negedge clk);
    applyStimulus(1, 1'b0, 18'h2FFFF, 16'd1);
    #1;
    checkOutput("errGrant", {30'b0, req_ready}, 32'h2);
    @(negedge clk);
    req_valid = '0;
    applyStimulus(0, 1'b0, 18'h00010, 16'd0);
    #1;
    checkOutput("errPulse", {30'b0, err}, 32'h2);
    checkOutput("errNoCs", {31'b0, mem_cs}, 32'h0);
    checkOutput("errNextGrant", {30'b0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = '0;
    #1;
    checkOutput("errCleared", {30'b0, err}, 32'h0);
    checkOutput("errNextAddr", {13'b0, mem_cs, mem_addr}, 32'h40010);
    @(negedge clk);
    #1;
    checkOutput("errNextData", rdata, 32'h0000_0011);
    checkOutput("errNextDone", {28'b0, rvalid, done}, 32'h5);

    // Reset during beat 2 of an 8-beat read
    @(negedge clk);
    applyStimulus(1, 1'b0, 18'h00020, 16'd7);
    #1;
    checkOutput("rrsGrant", {30'b0, req_ready}, 32'h2);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checkOutput("rrsBeat2Addr", {14'b0, mem_addr}, 32'h21);
    rst = 1'b1;
    #1;
    checkOutput("rrsCtl", {29'b0, mem_cs, mem_oe, mem_web}, 32'h1);
    checkOutput("rrsAddr", {14'b0, mem_addr}, 32'h0);
    checkOutput("rrsPulses", {26'b0, rvalid, done, err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("rrsNoDone", {28'b0, done, rvalid}, 32'h0);
    end
    @(negedge clk);
    applyStimulus(0, 1'b0, 18'h00010, 16'd1);
    #1;
    checkOutput("rrsNextGrant", {30'b0, req_ready}, 32'h1);
    @(negedge clk);
    req_valid = '0;
    #1;
    checkOutput("rrsNextAddr0", {14'b0, mem_addr}, 32'h10);
    @(negedge clk);
    #1;
    checkOutput("rrsNextAddr1", {14'b0, mem_addr}, 32'h11);
    checkOutput("rrsNextData0", rdata, 32'h0000_0011);
    @(negedge clk);
    #1;
    checkOutput("rrsNextData1", rdata, 32'hFFFF_8022);
    checkOutput("rrsNextDone", {28'b0, rvalid, done}, 32'h5);

    // Fairness: both requesters held, len 0, 20 bursts
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1'b0, 18'h00010, 16'd0);
    applyStimulus(1, 1'b0, 18'h00011, 16'd0);
    grants0 = 0;
    grants1 = 0;
    for (int b = 0; b < 20; b++) begin
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        #1;
        if (req_ready != 2'b00) got = 1'b1;
        else @(negedge clk);
      end
      checkOutput("rrGrant", {30'b0, req_ready}, (b % 2 == 0) ? 32'h1 : 32'h2);
      grants0 += int'(req_ready[0]);
      grants1 += int'(req_ready[1]);
      @(negedge clk);
    end
    checkOutput("rrCount0", grants0, 32'd10);
    checkOutput("rrCount1", grants1, 32'd10);
    req_valid = '0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end
endmodule
